// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between the instruction buffer (IB) and the load/store buffer (LSB).
// Every access is serialised into byte cycles; LSB requests have priority over IB requests.
module memory_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        io_buffer_full,
    input  logic        ib_req,
    input  logic [31:0] ib_addr,
    output logic        ib_done,
    output logic [31:0] ib_data,
    input  logic        lsb_req,
    input  logic        lsb_we,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic        flush
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [1:0]  pidx_q, pidx_d;
    logic        frz_q, frz_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic        is_ib_q, is_ib_d;

    logic [1:0]  rd_idx;
    logic [31:0] wr_addr;
    logic        io_stall;
    logic [2:0]  lsb_len;

    always_comb begin
        case (lsb_size)
            2'b00:   lsb_len = 3'd1;
            2'b01:   lsb_len = 3'd2;
            default: lsb_len = 3'd4;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            pend_q  <= 1'b0;
            pidx_q  <= 2'd0;
            frz_q   <= 1'b0;
            base_q  <= 32'd0;
            len_q   <= 3'd0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
            is_ib_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pidx_q  <= pidx_d;
            frz_q   <= frz_d;
            base_q  <= base_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            is_ib_q <= is_ib_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pidx_d  = pidx_q;
        base_d  = base_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        is_ib_d = is_ib_q;
        frz_d   = ~rdy;

        ram_a    = 32'd0;
        ram_dout = 8'd0;
        ram_wr   = 1'b0;
        ib_done  = 1'b0;
        lsb_done = 1'b0;

        // After a freeze the byte in flight was lost, so the oldest unsampled byte is re-issued.
        rd_idx   = pend_q ? pidx_q : cnt_q[1:0];
        wr_addr  = base_q + {29'd0, cnt_q};
        io_stall = (wr_addr[17:16] == 2'b11) && io_buffer_full;

        case (state_q)
            IDLE: begin
                if (rdy) begin
                    if (lsb_req) begin
                        base_d  = lsb_addr;
                        wdata_d = lsb_wdata;
                        len_d   = lsb_len;
                        is_ib_d = 1'b0;
                        cnt_d   = 3'd0;
                        pend_d  = 1'b0;
                        pidx_d  = 2'd0;
                        data_d  = 32'd0;
                        state_d = lsb_we ? WRITE : READ;
                    end else if (ib_req && !flush) begin
                        base_d  = ib_addr;
                        wdata_d = 32'd0;
                        len_d   = 3'd4;
                        is_ib_d = 1'b1;
                        cnt_d   = 3'd0;
                        pend_d  = 1'b0;
                        pidx_d  = 2'd0;
                        data_d  = 32'd0;
                        state_d = READ;
                    end
                end
            end

            READ: begin
                if (frz_q) begin
                    ram_a = base_q + {30'd0, rd_idx};
                end else if (cnt_q < len_q) begin
                    ram_a = base_q + {29'd0, cnt_q};
                end
                if (rdy) begin
                    if (flush && is_ib_q) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                        pend_d  = 1'b0;
                    end else if (frz_q) begin
                        pend_d = 1'b1;
                        pidx_d = rd_idx;
                        cnt_d  = {1'b0, rd_idx} + 3'd1;
                    end else begin
                        if (pend_q) begin
                            data_d[{pidx_q, 3'b000} +: 8] = ram_din;
                        end
                        // Address issue runs one cycle ahead of sampling; the last sample ends the read.
                        if (cnt_q < len_q) begin
                            pend_d = 1'b1;
                            pidx_d = cnt_q[1:0];
                            cnt_d  = cnt_q + 3'd1;
                        end else begin
                            pend_d  = 1'b0;
                            cnt_d   = 3'd0;
                            state_d = DONE;
                        end
                    end
                end
            end

            WRITE: begin
                ram_a    = wr_addr;
                ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                if (rdy && !io_stall) begin
                    ram_wr = 1'b1;
                    if (cnt_q == len_q - 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            DONE: begin
                if (rdy) begin
                    ib_done  = is_ib_q && !flush;
                    lsb_done = !is_ib_q;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ib_data   = data_q;
    assign lsb_rdata = data_q;

endmodule
